proc_control_fsm: RTL and testbench
===================================

# proc_control_fsm

Control sequencer for the 16-bit DE1-SoC processor datapath. It fetches each instruction through R7 (the PC), decodes the latched IR, and steps the shared bus, ALU and memory interface through time steps T0–T5. It drives every datapath control line and pulses Done at the end of each instruction. The register file, ALU, flags register, IR register and bus mux live in the datapath, not in this block.

## Interface
Parameters: none. Width is fixed at 16 bits.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  start enable; sampled only in T0.
- IR  in  16  instruction register contents from the datapath.
  - III = IR[15:13], M = IR[12], rX = IR[11:9], D = IR[8:0], rY = IR[2:0].
- Z, C  in  1 each  registered zero and carry flags from the datapath.
- IRin, Ain, Gin, ADDRin, DOUTin  out  1 each  load enables for the corresponding datapath registers.
- Rin  out  8  one-hot register-file write enable; bit n writes Rn.
- incr_pc  out  1  R7 <= R7+1.
- W_D  out  1  memory write strobe.
- AddSub  out  1  ALU operation: 0 = add, 1 = subtract.
- AndOp  out  1  ALU performs bitwise AND; overrides AddSub.
- FlagsIn  out  1  load Z and C from the ALU result.
- Sel  out  4  bus source select:
  - 0–7: Rn
  - 8: G
  - 9: {7'b0,D}
  - 10: {D[8:0],7'b0}
  - 11: DIN
  - 12: sign-extended D
- Done  out  1  one-cycle end-of-instruction pulse.

## Operation
- States: T0 to T5, encoded as a 3-bit state register.
- Reset: state goes to T0. Every output is 0 while Reset=1 and in the cycle after Reset deasserts if Run=0.
- Outputs are combinational functions of the state and IR. Every output not listed for a step is 0.
- Fetch:
  - T0: if Run=0, hold T0 with all outputs 0. If Run=1, Sel=7, ADDRin=1, then go to T1.
  - T1: incr_pc=1 (memory read latency cycle).
  - T2: IRin=1.
- Execute, by opcode (T3 onward):
  - 000 mv: T3: Sel=9 if M=1, else Sel=rY; Rin[rX]=1; Done.
  - 001 M=1 mvt: T3: Sel=10, Rin[rX]=1, Done.
  - 001 M=0 branch. Condition is taken from rX: 000 always, 001 Z=1, 010 Z=0, 011 C=0, 100 C=1; 101–111 never taken. The condition is evaluated in T3.
    - Not taken: Done in T3, no Rin.
    - Taken: T3 Sel=7, Ain. T4 Sel=12, Gin, AddSub=0. T5 Sel=8, Rin[7]=1, Done.
  - 010 add, 011 sub, 110 and:
    - T3: Sel=rX, Ain.
    - T4: Sel=9 if M=1, else rY; Gin; FlagsIn; AddSub=1 for sub; AndOp=1 for and.
    - T5: Sel=8, Rin[rX]=1, Done.
  - 100 ld: T3 Sel=rY, ADDRin. T4 idle (memory latency). T5 Sel=11, Rin[rX]=1, Done.
  - 101 st: T3 Sel=rY, ADDRin. T4 Sel=rX, DOUTin, W_D=1, Done.
  - 111 (unused): treated as NOP; Done in T3.
- After any step asserting Done, the next state is T0.
- Rin is always one-hot or zero. rX=7 is legal and overwrites the PC.

## Timing
- Cycle counts from T0 with Run=1:
  - mv, mvt, NOP, branch not taken: 4 cycles.
  - st: 5 cycles.
  - add, sub, and, ld, branch taken: 6 cycles.
- Back-to-back instructions: T0 of the next instruction immediately follows the Done cycle.
- Run is ignored outside T0. Dropping Run mid-instruction completes the current instruction, then holds in T0.
- Reset has priority over every transition. Reset in any state gives T0 on the next edge with outputs 0, and an aborted st does not assert W_D.
- Z and C are sampled in T3 only. A FlagsIn in the same instruction cannot affect the branch decision.
- incr_pc is asserted only in T1, so it never coincides with Rin[7].

## Test plan
- Reset then Run=1, IR=0x1405 (mv r2,#5):
  - T0 Sel=7, ADDRin=1.
  - T1 incr_pc=1.
  - T2 IRin=1.
  - T3 Sel=9, Rin=8'h04, Done=1.
  - Next cycle back in T0.
- IR=0x4203 (add r1,r3):
  - T3 Sel=1, Ain.
  - T4 Sel=3, Gin, FlagsIn, AddSub=0.
  - T5 Sel=8, Rin=8'h02, Done.
  - Repeat with opcode 011 and check AddSub=1 in T4.
- IR=0xA805 (st r4,[r5]): T3 Sel=5, ADDRin. T4 Sel=4, DOUTin, W_D=1, Done. Total 5 cycles.
- IR=0x23FE (beq −2):
  - With Z=0: Done in T3, Rin=0.
  - With Z=1: T4 Sel=12, Gin. T5 Sel=8, Rin=8'h80, Done.
- IR=0x8006 (ld r0,[r6]), with Reset asserted in T4: next cycle T0 and all outputs 0.
  - Rerun without reset: T5 Sel=11, Rin=8'h01, Done.
- Run=0 held for 10 cycles after reset: state stays T0, no output asserted. Run dropped in T3 of an add: add completes, then the block idles in T0.

Source files
------------

// File: rtl/proc_control_fsm.sv
// Control sequencer for the 16-bit processor datapath: fetch via R7, decode IR,
// and step bus/ALU/memory controls through T0..T5, pulsing Done per instruction.
module proc_control_fsm (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic [15:0] IR,
  input  logic        Z,
  input  logic        C,
  output logic        IRin,
  output logic        Ain,
  output logic        Gin,
  output logic        ADDRin,
  output logic        DOUTin,
  output logic [7:0]  Rin,
  output logic        incr_pc,
  output logic        W_D,
  output logic        AddSub,
  output logic        AndOp,
  output logic        FlagsIn,
  output logic [3:0]  Sel,
  output logic        Done
);

  localparam int unsigned NREGS = 8;
  localparam int unsigned SELW  = 4;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVT = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;

  localparam logic [SELW-1:0] SEL_PC   = 4'd7;
  localparam logic [SELW-1:0] SEL_G    = 4'd8;
  localparam logic [SELW-1:0] SEL_D    = 4'd9;
  localparam logic [SELW-1:0] SEL_DHI  = 4'd10;
  localparam logic [SELW-1:0] SEL_DIN  = 4'd11;
  localparam logic [SELW-1:0] SEL_DSEX = 4'd12;

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [2:0]       iii, rx, ry;
  logic             m;
  logic [NREGS-1:0] rx_oh;
  logic             br_take;
  logic             unused_ir;

  assign iii       = IR[15:13];
  assign m         = IR[12];
  assign rx        = IR[11:9];
  assign ry        = IR[2:0];
  assign rx_oh     = NREGS'(1) << rx;
  assign unused_ir = ^IR[8:3];

  // Branch condition encoded in the rX field
  always_comb begin
    case (rx)
      3'b000:  br_take = 1'b1;
      3'b001:  br_take = Z;
      3'b010:  br_take = ~Z;
      3'b011:  br_take = ~C;
      3'b100:  br_take = C;
      default: br_take = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    IRin    = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    ADDRin  = 1'b0;
    DOUTin  = 1'b0;
    Rin     = '0;
    incr_pc = 1'b0;
    W_D     = 1'b0;
    AddSub  = 1'b0;
    AndOp   = 1'b0;
    FlagsIn = 1'b0;
    Sel     = '0;
    Done    = 1'b0;

    case (state_q)
      T0: begin
        if (Run) begin
          Sel     = SEL_PC;
          ADDRin  = 1'b1;
          state_d = T1;
        end
      end
      T1: begin
        incr_pc = 1'b1;
        state_d = T2;
      end
      T2: begin
        IRin    = 1'b1;
        state_d = T3;
      end
      T3: begin
        case (iii)
          OP_MV: begin
            Sel  = m ? SEL_D : SELW'(ry);
            Rin  = rx_oh;
            Done = 1'b1;
          end
          OP_MVT: begin
            if (m) begin
              Sel  = SEL_DHI;
              Rin  = rx_oh;
              Done = 1'b1;
            end else if (br_take) begin
              Sel     = SEL_PC;
              Ain     = 1'b1;
              state_d = T4;
            end else begin
              Done = 1'b1;
            end
          end
          OP_ADD, OP_SUB, OP_AND: begin
            Sel     = SELW'(rx);
            Ain     = 1'b1;
            state_d = T4;
          end
          OP_LD, OP_ST: begin
            Sel     = SELW'(ry);
            ADDRin  = 1'b1;
            state_d = T4;
          end
          default: Done = 1'b1;
        endcase
      end
      T4: begin
        case (iii)
          OP_MVT: begin
            Sel     = SEL_DSEX;
            Gin     = 1'b1;
            state_d = T5;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            Sel     = m ? SEL_D : SELW'(ry);
            Gin     = 1'b1;
            FlagsIn = 1'b1;
            AddSub  = (iii == OP_SUB);
            AndOp   = (iii == OP_AND);
            state_d = T5;
          end
          OP_LD:   state_d = T5;
          OP_ST: begin
            Sel    = SELW'(rx);
            DOUTin = 1'b1;
            W_D    = 1'b1;
            Done   = 1'b1;
          end
          default: state_d = T0;
        endcase
      end
      T5: begin
        case (iii)
          OP_MVT: begin
            Sel  = SEL_G;
            Rin  = NREGS'(8'h80);
            Done = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            Sel  = SEL_G;
            Rin  = rx_oh;
            Done = 1'b1;
          end
          OP_LD: begin
            Sel  = SEL_DIN;
            Rin  = rx_oh;
            Done = 1'b1;
          end
          default: state_d = T0;
        endcase
      end
      default: state_d = T0;
    endcase

    if (Done) state_d = T0;

    // Reset wins over every transition and silences all controls, including W_D
    if (Reset) begin
      state_d = T0;
      IRin    = 1'b0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      ADDRin  = 1'b0;
      DOUTin  = 1'b0;
      Rin     = '0;
      incr_pc = 1'b0;
      W_D     = 1'b0;
      AddSub  = 1'b0;
      AndOp   = 1'b0;
      FlagsIn = 1'b0;
      Sel     = '0;
      Done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Table-driven bench for proc_control_fsm: per-cycle expected controls plus
// instruction-length checks measured from T0 to Done.
module tb_proc_control_fsm;

  logic        Clock = 1'b0;
  logic        Reset, Run, Z, C;
  logic [15:0] IR;
  logic        IRin, Ain, Gin, ADDRin, DOUTin, incr_pc, W_D, AddSub, AndOp, FlagsIn, Done;
  logic [7:0]  Rin;
  logic [3:0]  Sel;

  proc_control_fsm dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR), .Z(Z), .C(C),
    .IRin(IRin), .Ain(Ain), .Gin(Gin), .ADDRin(ADDRin), .DOUTin(DOUTin),
    .Rin(Rin), .incr_pc(incr_pc), .W_D(W_D), .AddSub(AddSub), .AndOp(AndOp),
    .FlagsIn(FlagsIn), .Sel(Sel), .Done(Done)
  );

  always #5 Clock = ~Clock;

  // Flag bit order: IRin Ain Gin ADDRin DOUTin incr_pc W_D AddSub AndOp FlagsIn Done
  localparam logic [10:0] F_IRIN = 11'h400, F_AIN = 11'h200, F_GIN  = 11'h100,
                          F_ADDR = 11'h080, F_DOUT = 11'h040, F_INC = 11'h020,
                          F_WD   = 11'h010, F_SUB = 11'h008, F_AND  = 11'h004,
                          F_FLG  = 11'h002, F_DONE = 11'h001;

  typedef struct {
    logic        rst;
    logic        run;
    logic [15:0] ir;
    logic        z;
    logic        c;
    logic [3:0]  sel;
    logic [7:0]  rin;
    logic [10:0] fl;
    string       nm;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic p(input logic rst, input logic run, input logic [15:0] ir,
                   input logic z, input logic c, input logic [3:0] sel,
                   input logic [7:0] rin, input logic [10:0] fl, input string nm);
    vec_t v;
    v = '{rst: rst, run: run, ir: ir, z: z, c: c, sel: sel, rin: rin, fl: fl, nm: nm};
    vq.push_back(v);
  endtask

  // T0..T2 of a fetch with Run=1
  task automatic fetch(input logic [15:0] ir, input string nm);
    p(0, 1, ir, 0, 0, 4'd7, 8'h00, F_ADDR, {nm, "_t0"});
    p(0, 1, ir, 0, 0, 4'd0, 8'h00, F_INC,  {nm, "_t1"});
    p(0, 1, ir, 0, 0, 4'd0, 8'h00, F_IRIN, {nm, "_t2"});
  endtask

  task automatic apply(input vec_t v);
    logic [10:0] act;
    @(negedge Clock);
    Reset = v.rst; Run = v.run; IR = v.ir; Z = v.z; C = v.c;
    #1;
    act = {IRin, Ain, Gin, ADDRin, DOUTin, incr_pc, W_D, AddSub, AndOp, FlagsIn, Done};
    total++;
    if ({Sel, Rin, act} !== {v.sel, v.rin, v.fl}) begin
      bad++;
      $display("FAIL %s: got sel=%0d rin=%h flags=%h, want sel=%0d rin=%h flags=%h",
               v.nm, Sel, Rin, act, v.sel, v.rin, v.fl);
    end
  endtask

  // Cycles from T0 through Done inclusive, bounded
  task automatic count_instr(input logic [15:0] ir, input int exp, input string nm);
    int n;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      Reset = 0; Run = 1; IR = ir; Z = 0; C = 0;
      #1;
      n++;
      if (Done === 1'b1) break;
    end
    total++;
    if (n != exp) begin
      bad++;
      $display("FAIL %s: got %0d cycles, want %0d", nm, n, exp);
    end
  endtask

  initial begin
    Reset = 1; Run = 0; IR = '0; Z = 0; C = 0;

    // Reset with Run=1 still silences outputs, then Run=0 idle
    p(1, 1, 16'h1405, 0, 0, 4'd0, 8'h00, 11'h0, "reset_run1");
    for (int i = 0; i < 10; i++) p(0, 0, 16'h1405, 0, 0, 4'd0, 8'h00, 11'h0, "idle");

    // mv r2,#5 then back-to-back add r1,r3
    fetch(16'h1405, "mv_imm");
    p(0, 1, 16'h1405, 0, 0, 4'd9, 8'h04, F_DONE, "mv_imm_t3");
    fetch(16'h4203, "add");
    p(0, 1, 16'h4203, 0, 0, 4'd1, 8'h00, F_AIN, "add_t3");
    p(0, 1, 16'h4203, 0, 0, 4'd3, 8'h00, F_GIN | F_FLG, "add_t4");
    p(0, 1, 16'h4203, 0, 0, 4'd8, 8'h02, F_DONE, "add_t5");
    fetch(16'h6203, "sub");
    p(0, 1, 16'h6203, 0, 0, 4'd1, 8'h00, F_AIN, "sub_t3");
    p(0, 1, 16'h6203, 0, 0, 4'd3, 8'h00, F_GIN | F_FLG | F_SUB, "sub_t4");
    p(0, 1, 16'h6203, 0, 0, 4'd8, 8'h02, F_DONE, "sub_t5");
    // and r1,#3 (M=1)
    fetch(16'hD203, "and");
    p(0, 1, 16'hD203, 0, 0, 4'd1, 8'h00, F_AIN, "and_t3");
    p(0, 1, 16'hD203, 0, 0, 4'd9, 8'h00, F_GIN | F_FLG | F_AND, "and_t4");
    p(0, 1, 16'hD203, 0, 0, 4'd8, 8'h02, F_DONE, "and_t5");
    // st r4,[r5]
    fetch(16'hA805, "st");
    p(0, 1, 16'hA805, 0, 0, 4'd5, 8'h00, F_ADDR, "st_t3");
    p(0, 1, 16'hA805, 0, 0, 4'd4, 8'h00, F_DOUT | F_WD | F_DONE, "st_t4");
    // beq -2: not taken, then taken with Z dropping after T3
    fetch(16'h23FE, "beq_nt");
    p(0, 1, 16'h23FE, 0, 0, 4'd0, 8'h00, F_DONE, "beq_nt_t3");
    fetch(16'h23FE, "beq_t");
    p(0, 1, 16'h23FE, 1, 0, 4'd7, 8'h00, F_AIN, "beq_t_t3");
    p(0, 1, 16'h23FE, 0, 0, 4'd12, 8'h00, F_GIN, "beq_t_t4");
    p(0, 1, 16'h23FE, 0, 0, 4'd8, 8'h80, F_DONE, "beq_t_t5");
    // bcc with C=1 not taken; never-taken code 101; always-taken code 000
    fetch(16'h2600, "bcc");
    p(0, 1, 16'h2600, 0, 1, 4'd0, 8'h00, F_DONE, "bcc_nt_t3");
    fetch(16'h2A00, "bnever");
    p(0, 1, 16'h2A00, 1, 1, 4'd0, 8'h00, F_DONE, "bnever_t3");
    fetch(16'h2000, "br");
    p(0, 1, 16'h2000, 0, 0, 4'd7, 8'h00, F_AIN, "br_t3");
    p(0, 1, 16'h2000, 0, 0, 4'd12, 8'h00, F_GIN, "br_t4");
    p(0, 1, 16'h2000, 0, 0, 4'd8, 8'h80, F_DONE, "br_t5");
    // mvt r5, mv r7,r3 (writes PC), NOP
    fetch(16'h3A00, "mvt");
    p(0, 1, 16'h3A00, 0, 0, 4'd10, 8'h20, F_DONE, "mvt_t3");
    fetch(16'h0E03, "mv_reg");
    p(0, 1, 16'h0E03, 0, 0, 4'd3, 8'h80, F_DONE, "mv_reg_t3");
    fetch(16'hE000, "nop");
    p(0, 1, 16'hE000, 0, 0, 4'd0, 8'h00, F_DONE, "nop_t3");
    // ld r0,[r6] reset in T4, then idle, then full ld
    fetch(16'h8006, "ld_rst");
    p(0, 1, 16'h8006, 0, 0, 4'd6, 8'h00, F_ADDR, "ld_rst_t3");
    p(1, 1, 16'h8006, 0, 0, 4'd0, 8'h00, 11'h0, "ld_rst_t4");
    p(0, 0, 16'h8006, 0, 0, 4'd0, 8'h00, 11'h0, "ld_rst_after");
    fetch(16'h8006, "ld");
    p(0, 1, 16'h8006, 0, 0, 4'd6, 8'h00, F_ADDR, "ld_t3");
    p(0, 1, 16'h8006, 0, 0, 4'd0, 8'h00, 11'h0, "ld_t4");
    p(0, 1, 16'h8006, 0, 0, 4'd11, 8'h01, F_DONE, "ld_t5");
    // st aborted by reset in T4: no W_D
    fetch(16'hA805, "st_rst");
    p(0, 1, 16'hA805, 0, 0, 4'd5, 8'h00, F_ADDR, "st_rst_t3");
    p(1, 1, 16'hA805, 0, 0, 4'd0, 8'h00, 11'h0, "st_rst_t4");
    p(0, 0, 16'hA805, 0, 0, 4'd0, 8'h00, 11'h0, "st_rst_after");
    // Run dropped in T3 of add: completes, then idles
    fetch(16'h4203, "add_drop");
    p(0, 0, 16'h4203, 0, 0, 4'd1, 8'h00, F_AIN, "add_drop_t3");
    p(0, 0, 16'h4203, 0, 0, 4'd3, 8'h00, F_GIN | F_FLG, "add_drop_t4");
    p(0, 0, 16'h4203, 0, 0, 4'd8, 8'h02, F_DONE, "add_drop_t5");
    p(0, 0, 16'h4203, 0, 0, 4'd0, 8'h00, 11'h0, "add_drop_idle0");
    p(0, 0, 16'h4203, 0, 0, 4'd0, 8'h00, 11'h0, "add_drop_idle1");

    foreach (vq[i]) apply(vq[i]);

    // Instruction lengths, back to back from T0
    count_instr(16'h1405, 4, "len_mv");
    count_instr(16'hE000, 4, "len_nop");
    count_instr(16'hA805, 5, "len_st");
    count_instr(16'h4203, 6, "len_add");
    count_instr(16'h8006, 6, "len_ld");
    count_instr(16'h2000, 6, "len_br_taken");
    count_instr(16'h23FE, 4, "len_beq_nt");

    @(negedge Clock);
    Run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
